ps2_key_decoder: RTL

//  Receives the raw PS/2 keyboard serial stream and converts it to the 11-bit ps2_key event word consumed by the core tops.

---
 rtl/ps2_key_decoder.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: turns the raw PS/2 keyboard serial stream into an 11-bit key event word.
//   clk       in   system clock
//   reset     in   asynchronous active-high reset
//   ps2_clk   in   raw keyboard clock pin (asynchronous)
//   ps2_data  in   raw keyboard data pin (asynchronous)
//   ps2_key   out  {toggle, pressed, extended, scan code}; a new event flips bit 10
//   key_stb   out  one-cycle pulse when ps2_key updates
//   frame_err out  one-cycle pulse when a frame is rejected (framing/parity/timeout)
//   busy      out  high while a frame is being shifted in
module ps2_key_decoder #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [10:0] ps2_key,
    output logic        key_stb,
    output logic        frame_err,
    output logic        busy
);
    localparam int CW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]    s0, s1, filt;
    logic [CW-1:0] cnt [2];
    logic          clk_d;
    logic          e, d;
    state_t        state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shift;
    logic          par_ok;
    logic [TW-1:0] tmo;
    logic          byte_vld;
    logic          ext, brk;
    logic [2:0]    skip;

    // Index 0 carries the clock pin, index 1 the data pin; both see identical
    // delay so data is already settled when the clock edge is recognised.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s0     <= 2'b11;
            s1     <= 2'b11;
            filt   <= 2'b11;
            clk_d  <= 1'b1;
            cnt[0] <= '0;
            cnt[1] <= '0;
        end else begin
            s0    <= {ps2_data, ps2_clk};
            s1    <= s0;
            clk_d <= filt[0];
            for (int i = 0; i < 2; i++) begin
                if (s1[i] == filt[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CW'(FILTER_LEN - 1)) begin
                    filt[i] <= s1[i];
                    cnt[i]  <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign e    = clk_d & ~filt[0];
    assign d    = filt[1];
    assign busy = state != IDLE;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            shift     <= '0;
            par_ok    <= 1'b0;
            tmo       <= '0;
            byte_vld  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            byte_vld  <= 1'b0;
            frame_err <= 1'b0;
            if (e) begin
                tmo <= '0;
                unique case (state)
                    IDLE: begin
                        if (!d) begin
                            state   <= DATA;
                            bit_cnt <= '0;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    DATA: begin
                        shift   <= {d, shift[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7) state <= PARITY;
                    end
                    // The verdict is deferred to the stop edge so a bad parity
                    // frame still consumes its stop bit and raises one error.
                    PARITY: begin
                        par_ok <= ^{shift, d};
                        state  <= STOP;
                    end
                    STOP: begin
                        state <= IDLE;
                        if (d && par_ok) byte_vld <= 1'b1;
                        else frame_err <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end else if (state != IDLE) begin
                if (tmo == TW'(TIMEOUT_CYC)) begin
                    state     <= IDLE;
                    frame_err <= 1'b1;
                    tmo       <= '0;
                end else begin
                    tmo <= tmo + 1'b1;
                end
            end
        end
    end

    // shift holds the received byte until the next frame's data bits arrive,
    // far later than the cycle byte_vld is consumed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ps2_key <= '0;
            key_stb <= 1'b0;
            ext     <= 1'b0;
            brk     <= 1'b0;
            skip    <= '0;
        end else begin
            key_stb <= 1'b0;
            if (frame_err) begin
                ext  <= 1'b0;
                brk  <= 1'b0;
                skip <= '0;
            end else if (byte_vld) begin
                if (skip != 3'd0) begin
                    skip <= skip - 1'b1;
                end else if (shift == 8'hE0) begin
                    ext <= 1'b1;
                end else if (shift == 8'hF0) begin
                    brk <= 1'b1;
                end else if (shift == 8'hE1) begin
                    skip <= 3'd7;
                    ext  <= 1'b0;
                    brk  <= 1'b0;
                end else begin
                    ps2_key <= {~ps2_key[10], ~brk, ext, shift};
                    key_stb <= 1'b1;
                    ext     <= 1'b0;
                    brk     <= 1'b0;
                end
            end
        end
    end
endmodule
